// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-state encoding used by the fetch stage and the decoder.
package isa_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  // Opcode field position inside an instruction word.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection, fetch fault check and fetch-state transitions.
// Purely combinational; the fetch_unit top owns every register.
module fetch_pc_sel
  import isa_pkg::*;
#(
  parameter int         MEM_BYTES   = 512,
  parameter logic [3:0] HALT_OPCODE = isa_pkg::HALT_OPCODE
) (
  input  fetch_state_e      state_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_target_i,
  input  logic [3:0]        opcode_i,
  output fetch_state_e      state_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              latch_o,
  output logic              hold_o
);

  // Highest byte address at which a whole 16-bit word still fits in memory.
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_BYTES - 2);

  logic bad_pc;

  // An odd PC or one beyond the last word is a fault; PC+2 wrap lands here too.
  always_comb begin
    bad_pc = pc_i[0] || (pc_i > LAST_PC);
  end

  // Priority: redirect > stall > fault check > normal fetch; FAULT holds until reset.
  always_comb begin
    state_o = state_i;
    pc_o    = pc_i;
    latch_o = 1'b0;
    hold_o  = 1'b0;
    unique case (state_i)
      ST_RUN: begin
        if (redirect_valid_i) begin
          pc_o = redirect_target_i;
        end else if (stall_i) begin
          hold_o = 1'b1;
        end else if (bad_pc) begin
          state_o = ST_FAULT;
        end else begin
          latch_o = 1'b1;
          pc_o    = pc_i + PC_W'(2);
          if (opcode_i == HALT_OPCODE) begin
            state_o = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        // A redirect means the halt was on a wrong path; stall is irrelevant here.
        if (redirect_valid_i) begin
          pc_o    = redirect_target_i;
          state_o = ST_RUN;
        end
      end
      ST_FAULT: begin
        hold_o = 1'b1;
      end
      default: begin
        state_o = ST_FAULT;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, combinational instruction-memory
// address, IF/ID pipeline register, halt/fault state and delivered-count.
module fetch_unit
  import isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_BYTES   = 512,
  parameter logic [3:0]  HALT_OPCODE = isa_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_ins,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic [INSTR_W-1:0] id_ins,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus2,
  output logic               id_valid,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] id_ins_q;
  logic [PC_W-1:0]    id_pc_q;
  logic               id_vld_p1_q, id_vld_p1_d;
  logic [15:0]        fetch_count_q;
  logic               latch;
  logic               hold;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fetch_pc_sel #(
    .MEM_BYTES   (MEM_BYTES),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_pc_sel (
    .state_i           (state_q),
    .pc_i              (pc_q),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .opcode_i          (imem_ins[OPC_MSB:OPC_LSB]),
    .state_o           (state_d),
    .pc_o              (pc_d),
    .latch_o           (latch),
    .hold_o            (hold)
  );

  // Valid follows a fresh fetch, survives only a plain stall, otherwise drops to a bubble.
  always_comb begin
    id_vld_p1_d = 1'b0;
    if (latch) begin
      id_vld_p1_d = 1'b1;
    end else if (hold) begin
      id_vld_p1_d = id_vld_p1_q;
    end
  end

  // IF -> ID boundary: PC, state, IF/ID register and delivered-instruction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      id_ins_q      <= '0;
      id_pc_q       <= '0;
      id_vld_p1_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_vld_p1_q <= id_vld_p1_d;
      if (latch) begin
        id_ins_q      <= imem_ins;
        id_pc_q       <= pc_q;
        fetch_count_q <= sat_inc16(fetch_count_q);
      end
    end
  end

  assign imem_pc     = pc_q;
  assign id_ins      = id_ins_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus2 = id_pc_q + PC_W'(2);
  assign id_valid    = id_vld_p1_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of `InstructionMemory`. Owns the program counter, drives the byte address into the combinational instruction memory, and latches the returned 16-bit word into the IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect with flush, halt detection and out-of-range/misaligned fetch faults.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `MEM_BYTES`, 512, instruction memory size in bytes. The last legal fetch address is `MEM_BYTES-2`.
- `HALT_OPCODE`, 4'hF, value of `ins[15:12]` that halts fetch.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_pc`  out  16  byte address to the instruction memory; always equals the internal PC.
- `imem_ins`  in  16  instruction word returned combinationally for `imem_pc`.
- `stall`  in  1  hold the PC and the IF/ID register.
- `redirect_valid`  in  1  taken branch/jump; load the PC from `redirect_target`.
- `redirect_target`  in  16  new byte PC.
- `id_ins`  out  16  latched instruction.
- `id_pc`  out  16  address of `id_ins`.
- `id_pc_plus2`  out  16  `id_pc + 2`, modulo 2^16.
- `id_valid`  out  1  `id_ins` is a real instruction, not a bubble.
- `halted`  out  1  fetch is stopped on a halt.
- `fault`  out  1  sticky misaligned or out-of-range fetch.
- `fetch_count`  out  16  instructions delivered with `id_valid=1`; saturates at 16'hFFFF.

## Operation
- States: RUN, HALT, FAULT. Reset enters RUN.
- Reset values:
  - PC=`RESET_PC`.
  - `id_ins`=0, `id_pc`=0, `id_pc_plus2`=2.
  - `id_valid`=0, `halted`=0, `fault`=0, `fetch_count`=0.
- Priority in RUN: `rst` > `redirect_valid` > `stall` > normal fetch.
- Normal fetch (RUN, no stall, no redirect):
  - `id_ins`<=`imem_ins`, `id_pc`<=PC, `id_valid`<=1, PC<=PC+2.
  - `fetch_count` increments.
- Stall: PC and all `id_*` outputs hold; `fetch_count` holds.
- Redirect (any state except FAULT):
  - PC<=`redirect_target`, `id_valid`<=0 (flush); `id_ins` and `id_pc` hold.
  - Clears `halted` and returns to RUN.
  - Redirect overrides a simultaneous stall.
- Halt:
  - When a normal fetch latches a word with `imem_ins[15:12]==HALT_OPCODE`, that word is delivered with `id_valid=1`. The state becomes HALT, `halted`<=1 and the PC is frozen at the halt address + 2.
  - In HALT, from the next cycle: `id_valid`=0, `stall` is ignored, `fetch_count` holds.
  - A redirect exits HALT, because the halt was wrong-path.
- Fault:
  - Checked on the PC before a normal fetch: PC odd, or PC > `MEM_BYTES-2`.
  - Result: state FAULT, `fault`<=1, `id_valid`<=0, and the instruction is not latched.
  - A `redirect_target` that is itself odd or out of range causes the fault on the following cycle, when it becomes the PC.
  - FAULT is sticky: redirect and stall are ignored and only `rst` exits.
- Wrap-around: PC arithmetic is modulo 2^16. An overflow past `MEM_BYTES-2` is caught by the range check, never silently wrapped into memory.

## Timing
- `imem_pc` is combinational from the PC register. The memory read completes in the same cycle.
- Fetch-to-ID latency is one cycle. The first valid instruction, at `RESET_PC`, appears the cycle after `rst` deasserts.
- Redirect penalty:
  - Cycle N (`redirect_valid`=1): the current fetch is discarded.
  - N+1: `id_valid`=0 while the target is fetched.
  - N+2: the target instruction is in ID with `id_valid`=1.
- `rst` asserted mid-stall, mid-HALT or in FAULT takes effect at the next edge with all the reset values above.

## Structure
- Shared package `isa_pkg` holds:
  - `INSTR_W=16`, `PC_W=16`.
  - `HALT_OPCODE`.
  - The fetch-state enum (RUN/HALT/FAULT).
  - The opcode field slice constants [15:12], shared with the decoder.
- One sub-module, `fetch_pc_sel`: combinational next-PC mux, fault check, and next-state logic. The top holds the PC, state, IF/ID register and counter.

## Test plan
- Reset then run through memory words 0x1234 at 0 and 0xABCD at 2:
  - Cycle 1: `id_ins`=0x1234, `id_pc`=0, `id_valid`=1.
  - Cycle 2: `id_ins`=0xABCD, `id_pc_plus2`=4.
  - `fetch_count`=2.
- Stall held for 3 cycles at PC=4: `imem_pc` stays 4, the `id_*` outputs are unchanged and `fetch_count` is unchanged. Resuming delivers the word at 4.
- `redirect_valid` with target 0x0040 and `stall`=1 in the same cycle:
  - Next cycle: `id_valid`=0 and `imem_pc`=0x0040.
  - The cycle after: `id_pc`=0x0040, `id_valid`=1.
- Halt word 0xF000 at address 6:
  - It is delivered with `id_valid=1`, then `halted`=1, `id_valid`=0 and `imem_pc`=8 frozen.
  - A redirect to 0 resumes fetch and clears `halted`.
- Redirect to 0x0003 (odd): on the following cycle `fault`=1 and `id_valid`=0. Further redirects are ignored; `rst` clears `fault` and PC=0.
- Sequential fetch reaching PC=0x0200 with `MEM_BYTES`=512: `fault`=1, no word latched, and `fetch_count` stops at 256.
